// File: rtl/time_ctrl_pkg.sv
// rtl/time_ctrl_pkg.sv - mode encoding and defaults shared by the time-set controller
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_S  = 2'd1,
        SET_MI = 2'd2,
        SET_H  = 2'd3
    } mode_t;

    localparam int TIMEOUT_S_DEFAULT = 10;

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            RUN:     return SET_S;
            SET_S:   return SET_MI;
            SET_MI:  return SET_H;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-flop synchronizer for an active-low button with press (falling edge) pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic fall
);

    logic meta, sync, sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign fall  = sync_d & ~sync;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-set mode controller; TIME_SET_AUTO_EXIT_EN adds idle auto-exit
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_1s,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    output logic [1:0] mode,
    output logic       pulse_run,
    output logic       enable_cnt_s,
    output logic       enable_cnt_mi,
    output logic       enable_cnt_h,
    output logic       increase_s,
    output logic       decrease_s,
    output logic       increase_mi,
    output logic       decrease_mi,
    output logic       increase_h,
    output logic       decrease_h,
    output logic       blink
);

    mode_t state, state_nxt;
    logic  mode_lvl, mode_fall, inc_lvl, inc_fall, dec_lvl, dec_fall;
    logic  inc_mask, dec_mask, blink_q;
    logic  state_chg, timeout_hit, inc_fwd, dec_fwd;

    btn_sync_edge u_sync_mode (.clk(clk), .rst(rst), .btn(mode_btn), .level(mode_lvl), .fall(mode_fall));
    btn_sync_edge u_sync_inc  (.clk(clk), .rst(rst), .btn(inc_btn),  .level(inc_lvl),  .fall(inc_fall));
    btn_sync_edge u_sync_dec  (.clk(clk), .rst(rst), .btn(dec_btn),  .level(dec_lvl),  .fall(dec_fall));

    assign state_chg = (state_nxt != state);

`ifdef TIME_SET_AUTO_EXIT_EN
    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT_S);
    logic [3:0] idle_cnt;
    logic       any_press;

    assign any_press   = mode_fall | inc_fall | dec_fall;
    assign timeout_hit = (state != RUN) && pulse_1s && !any_press
                         && (idle_cnt + 4'd1 == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idle_cnt <= 4'd0;
        else if (state_chg || any_press)
            idle_cnt <= 4'd0;
        else if (state != RUN && pulse_1s)
            idle_cnt <= idle_cnt + 4'd1;
    end
`else
    logic unused_press;
    assign unused_press = &{1'b0, mode_lvl, inc_fall, dec_fall};
    assign timeout_hit  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mode_fall)
            state_nxt = next_mode(state);
        else if (timeout_hit)
            state_nxt = RUN;
    end

    // A button already held when a field is entered must be seen released before it is forwarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_mask <= 1'b1;
            dec_mask <= 1'b1;
            blink_q  <= 1'b0;
        end else begin
            if (state_chg)    inc_mask <= 1'b1;
            else if (inc_lvl) inc_mask <= 1'b0;
            if (state_chg)    dec_mask <= 1'b1;
            else if (dec_lvl) dec_mask <= 1'b0;
            if (state_chg)
                blink_q <= 1'b0;
            else if (state != RUN && pulse_1s)
                blink_q <= ~blink_q;
        end
    end

    // Both buttons low together cancel each other
    assign inc_fwd = inc_mask | inc_lvl | ~dec_lvl;
    assign dec_fwd = dec_mask | dec_lvl | ~inc_lvl;

    always_comb begin
        pulse_run     = 1'b0;
        enable_cnt_s  = 1'b0;
        enable_cnt_mi = 1'b0;
        enable_cnt_h  = 1'b0;
        increase_s    = 1'b1;
        decrease_s    = 1'b1;
        increase_mi   = 1'b1;
        decrease_mi   = 1'b1;
        increase_h    = 1'b1;
        decrease_h    = 1'b1;
        case (state)
            RUN: begin
                pulse_run     = pulse_1s & rst;
                enable_cnt_s  = 1'b1;
                enable_cnt_mi = 1'b1;
                enable_cnt_h  = 1'b1;
            end
            SET_S: begin
                enable_cnt_s = 1'b1;
                increase_s   = inc_fwd;
                decrease_s   = dec_fwd;
            end
            SET_MI: begin
                enable_cnt_mi = 1'b1;
                increase_mi   = inc_fwd;
                decrease_mi   = dec_fwd;
            end
            default: begin
                enable_cnt_h = 1'b1;
                increase_h   = inc_fwd;
                decrease_h   = dec_fwd;
            end
        endcase
    end

    assign mode  = state;
    assign blink = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_1s = 1'b0;
    logic       mode_btn = 1'b1;
    logic       inc_btn = 1'b1;
    logic       dec_btn = 1'b1;
    logic [1:0] mode;
    logic       pulse_run, enable_cnt_s, enable_cnt_mi, enable_cnt_h;
    logic       increase_s, decrease_s, increase_mi, decrease_mi, increase_h, decrease_h;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;

    logic       mon_on = 1'b0;
    logic       prev_inc_s = 1'b1;
    logic       prev_dec_s = 1'b1;
    int         inc_s_falls = 0;
    int         dec_s_falls = 0;
    int         other_lows = 0;
    int         run_highs = 0;

    time_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s),
        .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .mode(mode), .pulse_run(pulse_run),
        .enable_cnt_s(enable_cnt_s), .enable_cnt_mi(enable_cnt_mi), .enable_cnt_h(enable_cnt_h),
        .increase_s(increase_s), .decrease_s(decrease_s),
        .increase_mi(increase_mi), .decrease_mi(decrease_mi),
        .increase_h(increase_h), .decrease_h(decrease_h),
        .blink(blink)
    );

    always #5 clk = ~clk;

    wire [5:0] strobes = {increase_s, decrease_s, increase_mi, decrease_mi, increase_h, decrease_h};
    wire [2:0] enables = {enable_cnt_s, enable_cnt_mi, enable_cnt_h};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse();
        pulse_1s = 1'b1;
        step(1);
        pulse_1s = 1'b0;
    endtask

    task automatic press_mode(input logic [1:0] from_mode, input logic [1:0] to_mode);
        @(negedge clk);
        mode_btn = 1'b0;
        step(2);
        check("mode_before_3rd_edge", 32'(mode), 32'(from_mode));
        step(1);
        check("mode_at_3rd_edge", 32'(mode), 32'(to_mode));
        mode_btn = 1'b1;
        step(3);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (mon_on) begin
            if (prev_inc_s && !increase_s) inc_s_falls++;
            if (prev_dec_s && !decrease_s) dec_s_falls++;
            if (!(increase_mi && decrease_mi && increase_h && decrease_h)) other_lows++;
            if (pulse_run) run_highs++;
        end
        prev_inc_s = increase_s;
        prev_dec_s = decrease_s;
    end

    initial begin
        // reset state, with a tick arriving while reset is held
        pulse_1s = 1'b1;
        step(2);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_pulse_run", 32'(pulse_run), 32'd0);
        check("rst_enables", 32'(enables), 32'h7);
        check("rst_strobes", 32'(strobes), 32'h3F);
        check("rst_blink", 32'(blink), 32'd0);
        pulse_1s = 1'b0;
        rst = 1'b1;
        step(2);

        pulse_1s = 1'b1;
        #1;
        check("run_pulse_run", 32'(pulse_run), 32'd1);
        step(1);
        pulse_1s = 1'b0;

        // SET_S: two inc presses and one dec press
        press_mode(2'd0, 2'd1);
        check("set_s_enables", 32'(enables), 32'h4);
        mon_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inc_btn = 1'b0;
            step(3);
            check("set_s_inc_low", 32'(strobes), 32'h1F);
            inc_btn = 1'b1;
            step(3);
        end
        dec_btn = 1'b0;
        step(3);
        check("set_s_dec_low", 32'(strobes), 32'h2F);
        dec_btn = 1'b1;
        step(3);
        pulse();
        check("set_s_blink", 32'(blink), 32'd1);
        step(1);
        mon_on = 1'b0;
        check("set_s_inc_falls", 32'(inc_s_falls), 32'd2);
        check("set_s_dec_falls", 32'(dec_s_falls), 32'd1);
        check("set_s_other_lows", 32'(other_lows), 32'd0);
        check("set_s_pulse_run", 32'(run_highs), 32'd0);

        // hold inc across the change into SET_MI
        inc_btn = 1'b0;
        step(3);
        check("hold_inc_s_low", 32'(increase_s), 32'd0);
        press_mode(2'd1, 2'd2);
        check("hold_blink_cleared", 32'(blink), 32'd0);
        check("hold_strobes_masked", 32'(strobes), 32'h3F);
        step(5);
        check("hold_still_masked", 32'(strobes), 32'h3F);
        inc_btn = 1'b1;
        step(3);
        check("release_mi_high", 32'(increase_mi), 32'd1);
        inc_btn = 1'b0;
        step(3);
        check("repress_mi_low", 32'(strobes), 32'h37);
        inc_btn = 1'b1;
        step(3);
        check("repress_mi_release", 32'(strobes), 32'h3F);

        // SET_H: both buttons cancel, blink toggling, coincident tick on exit
        press_mode(2'd2, 2'd3);
        check("set_h_enables", 32'(enables), 32'h1);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        step(4);
        check("set_h_both_low", 32'(strobes), 32'h3F);
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        step(3);
        pulse();
        check("blink_tick1", 32'(blink), 32'd1);
        pulse();
        check("blink_tick2", 32'(blink), 32'd0);
        pulse();
        check("blink_tick3", 32'(blink), 32'd1);
        @(negedge clk);
        mode_btn = 1'b0;
        step(2);
        check("exit_h_mode_before", 32'(mode), 32'd3);
        pulse_1s = 1'b1;
        #1;
        check("exit_h_pulse_run", 32'(pulse_run), 32'd0);
        step(1);
        pulse_1s = 1'b0;
        #1;
        check("exit_h_mode", 32'(mode), 32'd0);
        check("exit_h_blink", 32'(blink), 32'd0);
        mode_btn = 1'b1;
        step(3);

        // idle behaviour in SET_S
        press_mode(2'd0, 2'd1);
`ifdef TIME_SET_AUTO_EXIT_EN
        pulse();
        pulse();
        check("idle_after_2", 32'(mode), 32'd1);
        pulse();
        check("idle_timeout", 32'(mode), 32'd0);
        press_mode(2'd0, 2'd1);
        press_mode(2'd1, 2'd2);
`else
        for (int i = 0; i < 20; i++) pulse();
        check("idle_no_exit", 32'(mode), 32'd1);
        press_mode(2'd1, 2'd2);
`endif

        // reset in the middle of an edit
        inc_btn = 1'b0;
        step(3);
        check("edit_mi_low", 32'(increase_mi), 32'd0);
        #2;
        rst = 1'b0;
        pulse_1s = 1'b1;
        #1;
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_strobes", 32'(strobes), 32'h3F);
        check("midrst_pulse_run", 32'(pulse_run), 32'd0);
        pulse_1s = 1'b0;
        step(2);
        rst = 1'b1;
        inc_btn = 1'b1;
        step(4);
        check("post_rst_strobes", 32'(strobes), 32'h3F);
        pulse_1s = 1'b1;
        #1;
        check("post_rst_pulse_run", 32'(pulse_run), 32'd1);
        step(1);
        pulse_1s = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_S, default 10, idle seconds in a set mode before auto-exit; legal range 1..15.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 pulse_1s  input  1  one-clk-wide tick, once per second.
REQ-005 mode_btn, inc_btn, dec_btn  input  1 each  debounced push buttons, active-low, asynchronous to clk.
REQ-006 mode  output  2  current state: 0 RUN, 1 SET_S, 2 SET_MI, 3 SET_H.
REQ-007 pulse_run  output  1  pulse_1s gated to RUN only; feeds the seconds counter tick input.
REQ-008 enable_cnt_s, enable_cnt_mi, enable_cnt_h  output  1 each  counter enables.
REQ-009 increase_s/decrease_s, increase_mi/decrease_mi, increase_h/decrease_h  output  1 each  active-low level strobes to the counters, idle 1.
REQ-010 blink  output  1  display blank toggle for the field being edited.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer; a press is a 1-to-0 transition of the synchronized value.
REQ-012 A mode press SHALL advance state RUN->SET_S->SET_MI->SET_H->RUN; mode updates on the 3rd rising clk edge after mode_btn falls (setup met).
REQ-013 RUN: all enables 1, pulse_run = pulse_1s combinationally, all inc/dec outputs 1, blink 0.
REQ-014 SET_x: only the selected field's enable is 1, pulse_run 0, other fields' inc/dec outputs 1.
REQ-015 SET_x: selected field's increase_x/decrease_x SHALL follow the synchronized inc_btn/dec_btn level.
REQ-016 On entering any SET state, inc/dec forwarding SHALL stay masked (outputs 1) until each button is observed high, preventing a spurious falling edge at the counter.
REQ-017 inc_btn and dec_btn both synchronized low: both forwarded outputs SHALL be 1.
REQ-018 blink SHALL toggle on each pulse_1s in SET states, clear to 0 on every state change.
REQ-019 A mode press while inc/dec held SHALL drive the old field's outputs to 1 on the same edge the state changes.
REQ-020 pulse_1s coincident with a mode press leaving SET_H: pulse_run SHALL stay 0 for that tick.

Reset
REQ-021 rst low SHALL immediately force: state RUN, mode 0, synchronizers 1, masks set, blink 0, timeout counter 0.
REQ-022 During reset, outputs SHALL be: enables 1, pulse_run 0, all inc/dec 1, blink 0; reset mid-edit SHALL abandon the edit with no strobe emitted.

Configuration
REQ-023 Macro TIME_SET_AUTO_EXIT_EN defined: a 4-bit idle counter SHALL count pulse_1s in SET states, clear on any button press or state change, and force RUN on the tick that makes it equal TIMEOUT_S.
REQ-024 Macro undefined: no idle counter is built; SET states exit only via mode press or reset.

Structure
REQ-025 Shared package time_ctrl_pkg SHALL hold the mode state encoding (RUN/SET_S/SET_MI/SET_H) and the TIMEOUT_S default constant.
REQ-026 Sub-module btn_sync_edge (2-flop sync, synchronized level output, falling-edge pulse output) SHALL be instantiated three times.
REQ-027 Target size 150-300 lines of RTL including the sub-module.

Verification
REQ-028 Reset, then 3 mode presses -> mode 1,2,3 in turn, 4th press -> mode 0; each change exactly 3 clk after button fall.
REQ-029 SET_S, pulse 2 inc presses and 1 dec press -> increase_s low twice, decrease_s low once, all mi/h strobes stay 1, pulse_run 0 throughout.
REQ-030 Hold inc_btn low, press mode into SET_MI -> increase_mi stays 1 until inc_btn released, next press produces one low strobe.
REQ-031 SET_H, inc_btn and dec_btn low together -> increase_h and decrease_h both 1; blink toggles on each of 3 pulse_1s ticks then 0 after mode press.
REQ-032 With TIME_SET_AUTO_EXIT_EN, TIMEOUT_S=3, enter SET_S, no buttons -> mode returns to 0 on 3rd pulse_1s; without macro mode stays 1 after 20 ticks.
REQ-033 Assert rst in SET_MI with inc held -> mode 0, all strobes 1 immediately, pulse_run follows pulse_1s after release.
